// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame constants and the
// bit-period helper that the transmitter and receiver both use.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clocks per serial bit.
  function automatic int calc_tick_cnt(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between an upstream producer and the UART transmitter.
interface uart_transmitter_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 valid_in;
  logic                 ready;

  modport master (output data_in, output valid_in, input ready);
  modport slave  (input data_in, input valid_in, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering bytes ahead of the serialiser.
// Head is read combinationally so the FSM can load it on the pop edge.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers and occupancy; simultaneous push/pop leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO. tx is a registered decode of
// the current state, so the line lags the FSM by one clock; every bit is
// still held exactly TICK_CNT cycles.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 25000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  uart_transmitter_if.slave s_if,
  output logic             tx,
  output logic             busy
);
  localparam int TICK_CNT = calc_tick_cnt(CLK_FREQ, BAUD_RATE);
  localparam int TW       = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam int BW       = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_CNT - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

  if (TICK_CNT < 2) begin : g_tick_chk
    $error("uart_transmitter: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("uart_transmitter: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_tx_state_t       r_state, w_state_next;
  logic [TW-1:0]        r_tick, w_tick_next;
  logic [BW-1:0]        r_bit_idx, w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx, w_tx_next;
  logic                 w_pop, w_push, w_full, w_empty, w_tick_zero;
  logic [DATA_BITS-1:0] w_head;

  assign w_push     = s_if.valid_in && !w_full;
  assign s_if.ready = !w_full;
  assign tx         = r_tx;
  assign busy       = (r_state != IDLE) || !w_empty;
  assign w_tick_zero = (r_tick == '0);

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (s_if.data_in),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next state, bit timing and line level; STOP chains straight into START.
  always_comb begin
    w_state_next   = r_state;
    w_tick_next    = r_tick;
    w_bit_idx_next = r_bit_idx;
    w_pop          = 1'b0;
    w_tx_next      = 1'b1;
    case (r_state)
      IDLE: begin
        w_tick_next = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = START;
          w_tick_next  = TICK_RELOAD;
        end
      end
      START: begin
        w_tx_next = 1'b0;
        if (w_tick_zero) begin
          w_state_next   = DATA;
          w_bit_idx_next = '0;
          w_tick_next    = TICK_RELOAD;
        end else begin
          w_tick_next = r_tick - 1'b1;
        end
      end
      DATA: begin
        w_tx_next = r_shift[r_bit_idx];
        if (w_tick_zero) begin
          w_tick_next = TICK_RELOAD;
          if (r_bit_idx == LAST_BIT) w_state_next = STOP;
          else                       w_bit_idx_next = r_bit_idx + 1'b1;
        end else begin
          w_tick_next = r_tick - 1'b1;
        end
      end
      STOP: begin
        if (w_tick_zero) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = START;
            w_tick_next  = TICK_RELOAD;
          end else begin
            w_state_next = IDLE;
            w_tick_next  = '0;
          end
        end else begin
          w_tick_next = r_tick - 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM state, counters and registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tick    <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_tick    <= w_tick_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
    end
  end

  // Load the popped byte for serialisation.
  always_ff @(posedge clk) begin
    if (w_pop) r_shift <= w_head;
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at default parameters (4 clocks/bit).
module tb_uart_transmitter;
  localparam int TICK = 4;

  logic clk = 1'b0;
  logic reset;
  logic tx, busy;
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;

  uart_transmitter_if u_if();

  uart_transmitter #(.CLK_FREQ(100000000), .BAUD_RATE(25000000), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .s_if  (u_if.slave),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Serial line decoder: samples mid-bit, records each byte and its start cycle.
  logic [7:0] q_rx[$];
  int         q_st[$];
  int         mon_pos = -1, mon_start = 0, mon_err = 0;
  logic [7:0] mon_byte = '0;
  initial begin
    forever begin
      @(posedge clk); #2;
      if (reset) mon_pos = -1;
      else if (mon_pos < 0) begin
        if (tx == 1'b0) begin mon_pos = 0; mon_start = cyc; end
      end else begin
        mon_pos++;
        if (mon_pos % TICK == TICK/2) begin
          if (mon_pos / TICK == 0) begin
            if (tx !== 1'b0) begin mon_err++; mon_pos = -1; end
          end else if (mon_pos / TICK <= 8) begin
            mon_byte[mon_pos/TICK - 1] = tx;
          end else begin
            if (tx === 1'b1) begin q_rx.push_back(mon_byte); q_st.push_back(mon_start); end
            else mon_err++;
            mon_pos = -1;
          end
        end
      end
    end
  end

  task automatic push_now(input logic [7:0] b);
    u_if.data_in = b; u_if.valid_in = 1'b1;
    tick();
    u_if.valid_in = 1'b0;
  endtask

  // Hold valid until the byte is taken, as an upstream producer would.
  task automatic push_hold(input logic [7:0] b);
    int k; logic r;
    u_if.data_in = b; u_if.valid_in = 1'b1; k = 0;
    do begin r = u_if.ready; tick(); k++; end while (!r && k < 200);
    u_if.valid_in = 1'b0;
    chk("push_accept", 32'(r), 32'd1);
  endtask

  task automatic wait_idle();
    int k; k = 0;
    while ((busy || mon_pos >= 0) && k < 600) begin tick(); k++; end
    chk("idle_wait", 32'(busy), 32'd0);
    repeat (3) tick();
    q_rx.delete(); q_st.delete();
  endtask

  task automatic wait_rx(input int n, input int limit);
    int k; k = 0;
    while (q_rx.size() < n && k < limit) begin tick(); k++; end
    chk("rx_count", 32'(q_rx.size()), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] a5_frame;
    logic seen_low;
    int   kc, k;
    reset = 1'b1; u_if.valid_in = 1'b0; u_if.data_in = '0;
    tick(); tick();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(u_if.ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(); tick();
    chk("idle_tx", 32'(tx), 32'd1);

    // Single 0xA5: latency then exact per-cycle waveform.
    a5_frame = 10'b1101001010;  // bit0 = start, bits 1..8 = 1,0,1,0,0,1,0,1, bit9 = stop
    q_rx.delete(); q_st.delete();
    push_now(8'hA5);
    chk("lat_k_tx", 32'(tx), 32'd1);
    chk("lat_k_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_k1_tx", 32'(tx), 32'd1);
    tick();
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("a5_cyc%0d", i), 32'(tx), 32'(a5_frame[i/4]));
      if (i == 38) chk("a5_busy_stop", 32'(busy), 32'd1);
      if (i < 39) tick();
    end
    tick();
    chk("a5_busy_end", 32'(busy), 32'd0);
    chk("a5_tx_end", 32'(tx), 32'd1);
    chk("a5_rx_n", 32'(q_rx.size()), 32'd1);
    if (q_rx.size() > 0) chk("a5_rx", 32'(q_rx[0]), 32'hA5);

    // Six pushes with valid held: buffer fills, frames run back to back.
    wait_idle();
    for (int b = 0; b < 6; b++) begin
      push_hold(8'(b));
      if (b == 4) chk("full_ready", 32'(u_if.ready), 32'd0);
    end
    wait_rx(6, 400);
    for (int i = 0; i < 6 && i < q_rx.size(); i++) chk($sformatf("b2b_byte%0d", i), 32'(q_rx[i]), 32'(i));
    for (int i = 1; i < 6 && i < q_st.size(); i++) chk($sformatf("b2b_gap%0d", i), q_st[i] - q_st[i-1], 32'd40);
    if (q_st.size() == 6) chk("b2b_total", q_st[5] - q_st[0] + 40, 32'd240);

    // Byte offered while full is dropped.
    wait_idle();
    for (int b = 0; b < 5; b++) push_hold(8'hA0 + 8'(b));
    chk("drop_ready", 32'(u_if.ready), 32'd0);
    push_now(8'h3C);
    wait_rx(5, 400);
    repeat (60) tick();
    chk("drop_rx_n", 32'(q_rx.size()), 32'd5);
    for (int i = 0; i < 5 && i < q_rx.size(); i++) chk($sformatf("drop_byte%0d", i), 32'(q_rx[i]), 32'hA0 + 32'(i));

    // Push on the same edge as the STOP->START pop.
    wait_idle();
    push_now(8'hB0);
    kc = cyc;
    repeat (kc + 9 - cyc) tick();
    push_now(8'hB1);
    repeat (kc + 40 - cyc) tick();
    push_now(8'hB2);
    chk("same_edge_ready", 32'(u_if.ready), 32'd1);
    chk("same_edge_busy", 32'(busy), 32'd1);
    wait_rx(3, 300);
    for (int i = 0; i < 3 && i < q_rx.size(); i++) chk($sformatf("se_byte%0d", i), 32'(q_rx[i]), 32'hB0 + 32'(i));
    for (int i = 1; i < 3 && i < q_st.size(); i++) chk($sformatf("se_gap%0d", i), q_st[i] - q_st[i-1], 32'd40);

    // Reset at cycle 17 of a 0xFF frame with another byte queued.
    wait_idle();
    push_now(8'hFF);
    k = 0;
    while (tx !== 1'b0 && k < 10) begin tick(); k++; end
    chk("ff_start", 32'(tx), 32'd0);
    push_now(8'h11);
    repeat (15) tick();
    chk("ff_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(u_if.ready), 32'd1);
    reset = 1'b0;
    seen_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1) seen_low = 1'b1;
    end
    chk("post_rst_line", 32'(seen_low), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_rx", 32'(q_rx.size()), 32'd0);
    chk("framing", 32'(mon_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
